// File: rtl/sigmoid_pkg.sv
// Shared Q8.8 constants and the neuron MAC FSM encoding. The sigmoid stage
// and its bench import the same constants.
package sigmoid_pkg;

    localparam int FRAC  = 8;
    localparam int Q_ONE = 256;
    localparam int Q_MAX = 32767;
    localparam int Q_MIN = -32768;

    // IDLE waits for a first beat; ACCUM is inside a vector.
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } mac_state_t;

endpackage : sigmoid_pkg

// File: rtl/sigmoid_neuron_mac_if.sv
// Beat stream into the neuron MAC and pre-activation stream out of it.
// master = upstream feeder, slave = the MAC itself.
interface sigmoid_neuron_mac_if #(
    parameter int DATA_W = 16
);
    logic                     valid_in;
    logic                     first_in;
    logic                     last_in;
    logic signed [DATA_W-1:0] a_in;
    logic signed [DATA_W-1:0] w_in;
    logic signed [DATA_W-1:0] bias_in;
    logic signed [DATA_W-1:0] x_out;
    logic                     valid_out;
    logic                     sat_out;
    logic                     err_out;

    modport master (
        output valid_in, first_in, last_in, a_in, w_in, bias_in,
        input  x_out, valid_out, sat_out, err_out
    );

    modport slave (
        input  valid_in, first_in, last_in, a_in, w_in, bias_in,
        output x_out, valid_out, sat_out, err_out
    );
endinterface : sigmoid_neuron_mac_if

// File: rtl/q_round_sat.sv
// Combinational quantiser: takes a wide fixed-point sum with 2*FRAC fraction
// bits, rounds half toward +inf to FRAC fraction bits and clamps to the
// signed DATA_W range.
module q_round_sat #(
    parameter int ACC_W  = 40,
    parameter int DATA_W = 16,
    parameter int FRAC   = 8
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    output logic signed [DATA_W-1:0] o_q,
    output logic                     o_sat
);

    localparam logic signed [ACC_W-1:0] HALF =
        {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [ACC_W-1:0] MAX_EXT =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_EXT =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] w_biased;
    logic signed [ACC_W-1:0] w_shift;

    // Adding half an LSB before the arithmetic shift gives round-half-up.
    assign w_biased = i_acc + HALF;
    assign w_shift  = w_biased >>> FRAC;

    // Clamp to the output range and flag whenever clamping happened.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        o_q   = w_shift[DATA_W-1:0];
        o_sat = 1'b0;
        if (w_shift > MAX_EXT) begin
            o_q   = MAX_EXT[DATA_W-1:0];
            o_sat = 1'b1;
        end else if (w_shift < MIN_EXT) begin
            o_q   = MIN_EXT[DATA_W-1:0];
            o_sat = 1'b1;
        end
    end

endmodule : q_round_sat

// File: rtl/sigmoid_neuron_mac.sv
// Neuron multiply-accumulate feeding the sigmoid stage. Streams (a, w) beats,
// accumulates bias + sum(a*w) and emits one rounded, saturated Q8.8 sample
// per completed vector. Pipeline: S1 multiply, S2 accumulate, S3 quantise.
module sigmoid_neuron_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int FRAC   = 8
) (
    input logic               clk,
    input logic               rst_n,
    sigmoid_neuron_mac_if.slave bus
);
    import sigmoid_pkg::*;

    localparam int PROD_W = 2 * DATA_W;

    mac_state_t r_state;
    mac_state_t w_state_nxt;
    logic       w_accept;
    logic       w_err;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_bias_sh;

    logic                     r_s1_valid;
    logic                     r_s1_first;
    logic                     r_s1_last;
    logic signed [PROD_W-1:0] r_s1_prod;
    logic signed [ACC_W-1:0]  r_s1_bias;
    logic                     r_err;

    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_s2_valid;

    logic signed [DATA_W-1:0] w_q;
    logic                     w_sat;
    logic signed [DATA_W-1:0] r_x;
    logic                     r_sat;
    logic                     r_valid_out;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_state <= w_state_nxt;
        end
    end

    // Beat acceptance, protocol-error detection and next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_err       = 1'b0;
        if (bus.valid_in) begin
            unique case (r_state)
                IDLE: begin
                    if (bus.first_in) begin
                        w_accept    = 1'b1;
                        w_state_nxt = bus.last_in ? IDLE : ACCUM;
                    end else begin
                        // Orphan beat with no vector open: drop it.
                        w_err = 1'b1;
                    end
                end
                ACCUM: begin
                    // A first beat here restarts the vector; S2 reloads
                    // the accumulator so the partial sum is abandoned.
                    w_accept    = 1'b1;
                    w_err       = bus.first_in;
                    w_state_nxt = bus.last_in ? IDLE : ACCUM;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_prod    = bus.a_in * bus.w_in;
    assign w_bias_sh = {{(ACC_W-DATA_W){bus.bias_in[DATA_W-1]}}, bus.bias_in} <<< FRAC;

    // S1: register the product, framing bits, aligned bias and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_bias  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_first <= bus.first_in;
            r_s1_last  <= bus.last_in;
            r_s1_prod  <= w_prod;
            r_s1_bias  <= w_bias_sh;
            r_err      <= w_err;
        end
    end

    assign w_prod_ext = {{(ACC_W-PROD_W){r_s1_prod[PROD_W-1]}}, r_s1_prod};

    // S2: reload on the first beat, accumulate otherwise, hold across gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid & r_s1_last;
            if (r_s1_valid) begin
                r_acc <= r_s1_first ? (r_s1_bias + w_prod_ext)
                                    : (r_acc + w_prod_ext);
            end
        end
    end

    q_round_sat #(
        .ACC_W (ACC_W),
        .DATA_W(DATA_W),
        .FRAC  (FRAC)
    ) u_q_round_sat (
        .i_acc(r_acc),
        .o_q  (w_q),
        .o_sat(w_sat)
    );

    // S3: capture the quantised sum when a vector completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_sat       <= 1'b0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= r_s2_valid;
            if (r_s2_valid) begin
                r_x   <= w_q;
                r_sat <= w_sat;
            end
        end
    end

    assign bus.x_out     = r_x;
    assign bus.sat_out   = r_sat;
    assign bus.valid_out = r_valid_out;
    assign bus.err_out   = r_err;

endmodule : sigmoid_neuron_mac

// File: doc/sigmoid_neuron_mac.md
Name: sigmoid_neuron_mac

Overview:
Upstream feeder for the sigmoid activation pipeline. It streams (activation, weight) pairs for one neuron and accumulates the products. It adds a bias, then rounds and saturates the sum to signed Q8.8. It emits one x_out/valid_out per vector, which connects directly to the sigmoid stage's x_in/valid_in. There is no backpressure, because the sigmoid stage accepts one sample per cycle unconditionally.

Parameters:
DATA_W, 16, width of a_in, w_in, bias_in and x_out; all are signed Q8.8.
ACC_W, 40, accumulator width; signed Q24.16. Must be >= 2*DATA_W+8.
FRAC, 8, fractional bits of the Q-format.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
valid_in  in  1  beat qualifier
first_in  in  1  first beat of a vector; bias_in is sampled on this beat
last_in  in  1  last beat of a vector
a_in  in  DATA_W  signed Q8.8 activation
w_in  in  DATA_W  signed Q8.8 weight
bias_in  in  DATA_W  signed Q8.8 bias, valid only with valid_in&first_in
x_out  out  DATA_W  signed Q8.8 pre-activation
valid_out  out  1  one-cycle pulse, x_out valid
sat_out  out  1  qualified by valid_out; x_out was clamped
err_out  out  1  one-cycle protocol-error pulse

Behaviour:
- One clock domain. Reset is asynchronous and active-low (rst_n). All registers clear on reset: x_out=0, valid_out=0, sat_out=0, err_out=0, FSM=IDLE, accumulator=0.
- FSM states: IDLE and ACCUM.
  - IDLE to ACCUM on valid_in&first_in&!last_in.
  - ACCUM to IDLE on valid_in&last_in.
  - valid_in&first_in&last_in is a single-term vector. It is accepted in either state and the FSM ends in IDLE.
- Pipeline has 3 registered stages:
  - S1 registers the product a_in*w_in (2*DATA_W bits, Q16.16). It also registers first, last, and bias sign-extended and shifted left by FRAC.
  - S2 updates the accumulator. On first, acc = bias<<FRAC + product; otherwise acc += product.
  - S3 rounds, saturates and registers x_out, sat_out and valid_out.
- Latency: valid_out is asserted exactly 3 cycles after the clock edge that samples the last beat. Throughput is one beat per cycle.
- Back-to-back vectors: a first beat in the cycle immediately after a last beat is legal. There is no bubble, and the S2 re-initialisation prevents any sum leakage between vectors.
- Gaps: valid_in=0 cycles inside a vector are allowed. The accumulator holds its value.
- Rounding: round half toward +inf. Compute acc + 2^(FRAC-1), then arithmetic shift right by FRAC.
- Saturation: clamp to [-32768, 32767]. sat_out=1 iff clamped.
- Accumulator overflow within ACC_W wraps silently. This is out of scope, and ACC_W sizing covers 256 full-scale terms.
- Protocol errors each produce an err_out pulse 1 cycle after the offending beat:
  - A valid beat without first_in while in IDLE is discarded.
  - A first_in beat while in ACCUM abandons the partial sum and restarts the vector with the new beat; no output is produced for the abandoned vector.
- Reset mid-vector: the partial sum and all in-flight stages are dropped, and no valid_out is produced.
- valid_out is never asserted for a vector that has not received its last beat.

Decomposition:
- Shared package sigmoid_pkg holds:
  - Q8.8 constants: FRAC=8, Q_ONE=256, Q_MAX=32767, Q_MIN=-32768.
  - The FSM state encoding.
- These constants are reused by the sigmoid stage's bench.
- One sub-module, q_round_sat. It is combinational: it takes an ACC_W input and produces the DATA_W rounded/saturated result and a sat flag. It is reused later by the activation-output quantiser.

Test Plan:
- Single-term: first=last=1, a=256, w=512, bias=0 -> x_out=512, sat=0, valid_out 3 cycles later.
- Three-term: a=256 for all three beats, w=-512 for all three beats, bias=-256 -> x_out=-1792 (-7.0). Repeat with bias=+256 -> -1280. Repeat with bias=0 -> -1536, then feed to the sigmoid stage and check that the chain runs end to end.
- Rounding: a=1, w=128, bias=0 -> x_out=1. Then a=1, w=-128 -> x_out=0. Then a=1, w=-129 -> x_out=-1.
- Saturation: 4 beats of a=32767, w=32767 -> x_out=32767, sat=1. 4 beats of a=-32768, w=32767 -> x_out=-32768, sat=1.
- Back-to-back and gaps: vector A (2 beats, result 512) is followed immediately by vector B (1 beat, result -256), with a 2-cycle valid_in=0 gap inside A -> two valid_out pulses in order, with no carry-over between vectors.
- Errors and reset:
  - A beat without first in IDLE -> err_out pulse and no output.
  - A first in mid-vector -> err_out pulse, and only the restarted vector's sum is output.
  - rst_n asserted mid-vector -> outputs go to 0 immediately and no valid_out follows.
